// File: rtl/cpu_alu_arbiter_pkg.sv
// Shared types and constants for the two-port ALU arbiter: RISC-V opcode/funct3
// codes, field widths and the per-request operation payload.
package cpu_alu_arbiter_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned F7_W    = 7;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned NPORTS  = 2;

  localparam logic [OPC_W-1:0] OPCODE_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPCODE_OP_IMM = 7'b0010011;

  localparam logic [F3_W-1:0] F3_ADD_SUB = 3'd0;
  localparam logic [F3_W-1:0] F3_SLL     = 3'd1;
  localparam logic [F3_W-1:0] F3_SLT     = 3'd2;
  localparam logic [F3_W-1:0] F3_SLTU    = 3'd3;
  localparam logic [F3_W-1:0] F3_XOR     = 3'd4;
  localparam logic [F3_W-1:0] F3_SRL_SRA = 3'd5;
  localparam logic [F3_W-1:0] F3_OR      = 3'd6;
  localparam logic [F3_W-1:0] F3_AND     = 3'd7;

  typedef struct packed {
    logic [F7_W-1:0]  funct7;
    logic [F3_W-1:0]  funct3;
    logic [OPC_W-1:0] opcode;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
  } alu_op_t;

  function automatic logic [NPORTS-1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/cpu_alu_arbiter_if.sv
// Request/response bundle between the two requesters and the ALU arbiter.
interface cpu_alu_arbiter_if #(
  parameter int unsigned TAG_WIDTH = 4
);
  import cpu_alu_arbiter_pkg::*;

  logic [NPORTS-1:0]         req_valid;
  logic [NPORTS-1:0]         req_ready;
  logic [NPORTS*F7_W-1:0]    req_funct7;
  logic [NPORTS*F3_W-1:0]    req_funct3;
  logic [NPORTS*OPC_W-1:0]   req_opcode;
  logic [NPORTS*XLEN-1:0]    req_a;
  logic [NPORTS*XLEN-1:0]    req_b;
  logic [NPORTS*TAG_WIDTH-1:0] req_tag;
  logic [NPORTS-1:0]         rsp_valid;
  logic [NPORTS-1:0]         rsp_ready;
  logic [XLEN-1:0]           rsp_result;
  logic [TAG_WIDTH-1:0]      rsp_tag;

  modport master (
    output req_valid, req_funct7, req_funct3, req_opcode, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_tag
  );

  modport slave (
    input  req_valid, req_funct7, req_funct3, req_opcode, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_tag
  );

endinterface

// File: rtl/cpu_alu.sv
// Combinational RV32I integer ALU for OP / OP-IMM instructions.
module cpu_alu
  import cpu_alu_arbiter_pkg::*;
(
  input  logic [F7_W-1:0]  funct7,
  input  logic [F3_W-1:0]  funct3,
  input  logic [OPC_W-1:0] opcode,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic [XLEN-1:0]  result
);

  logic               do_sub;
  logic [SHAMT_W-1:0] shamt;

  // Only register-register OP subtracts; funct7[5] in OP-IMM is immediate bits.
  assign do_sub = (opcode == OPCODE_OP) && funct7[5];
  assign shamt  = b[SHAMT_W-1:0];

  always_comb begin
    result = '0;
    case (funct3)
      F3_ADD_SUB: result = do_sub ? (a - b) : (a + b);
      F3_SLL:     result = a << shamt;
      F3_SLT:     result = XLEN'($signed(a) < $signed(b));
      F3_SLTU:    result = XLEN'(a < b);
      F3_XOR:     result = a ^ b;
      F3_SRL_SRA: result = funct7[5] ? $unsigned($signed(a) >>> shamt) : (a >> shamt);
      F3_OR:      result = a | b;
      F3_AND:     result = a & b;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/cpu_alu_rr_pick.sv
// Two-way round-robin grant: on contention the port that did not win last time wins.
module cpu_alu_rr_pick (
  input  logic [1:0] valid,
  input  logic       enable,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/cpu_alu_arbiter.sv
// Shares one cpu_alu between two requesters with a single registered result slot.
// Optional stall counters: define CPU_ALU_ARBITER_PERF_COUNTERS_EN.
module cpu_alu_arbiter
  import cpu_alu_arbiter_pkg::*;
#(
  parameter int unsigned TAG_WIDTH       = 4,
  parameter bit          INIT_LAST_GRANT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  cpu_alu_arbiter_if.slave bus
`ifdef CPU_ALU_ARBITER_PERF_COUNTERS_EN
  ,
  output logic [63:0]      perf_stall_count
`endif
);

  logic                 slot_full;
  logic                 slot_owner;
  logic                 last_grant;
  logic [XLEN-1:0]      result_q;
  logic [TAG_WIDTH-1:0] tag_q;

  logic                 slot_free;
  logic [NPORTS-1:0]    grant;
  logic                 sel;
  alu_op_t              op_sel;
  logic [TAG_WIDTH-1:0] tag_sel;
  logic [XLEN-1:0]      alu_result;

  assign bus.rsp_valid  = slot_full ? port_onehot(slot_owner) : 2'b00;
  assign bus.rsp_result = result_q;
  assign bus.rsp_tag    = tag_q;

  // Slot can be refilled on the same edge its current owner drains it.
  assign slot_free = !slot_full || (bus.rsp_valid[slot_owner] && bus.rsp_ready[slot_owner]);

  cpu_alu_rr_pick u_pick (
    .valid  (bus.req_valid),
    .enable (slot_free),
    .last   (last_grant),
    .grant  (grant)
  );

  assign bus.req_ready = grant;
  assign sel           = grant[1];

  always_comb begin
    op_sel.funct7 = sel ? bus.req_funct7[2*F7_W-1:F7_W]   : bus.req_funct7[F7_W-1:0];
    op_sel.funct3 = sel ? bus.req_funct3[2*F3_W-1:F3_W]   : bus.req_funct3[F3_W-1:0];
    op_sel.opcode = sel ? bus.req_opcode[2*OPC_W-1:OPC_W] : bus.req_opcode[OPC_W-1:0];
    op_sel.a      = sel ? bus.req_a[2*XLEN-1:XLEN]        : bus.req_a[XLEN-1:0];
    op_sel.b      = sel ? bus.req_b[2*XLEN-1:XLEN]        : bus.req_b[XLEN-1:0];
    tag_sel       = sel ? bus.req_tag[2*TAG_WIDTH-1:TAG_WIDTH] : bus.req_tag[TAG_WIDTH-1:0];
  end

  cpu_alu u_alu (
    .funct7 (op_sel.funct7),
    .funct3 (op_sel.funct3),
    .opcode (op_sel.opcode),
    .a      (op_sel.a),
    .b      (op_sel.b),
    .result (alu_result)
  );

  // Result slot and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_full  <= 1'b0;
      slot_owner <= 1'b0;
      last_grant <= INIT_LAST_GRANT;
      result_q   <= '0;
      tag_q      <= '0;
    end else if (|grant) begin
      slot_full  <= 1'b1;
      slot_owner <= sel;
      last_grant <= sel;
      result_q   <= alu_result;
      tag_q      <= tag_sel;
    end else if (slot_free) begin
      slot_full  <= 1'b0;
    end
  end

`ifdef CPU_ALU_ARBITER_PERF_COUNTERS_EN
  logic [31:0] stall_cnt [NPORTS];

  // Saturating count of cycles each port waits with valid high.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NPORTS); i++) begin
      if (reset) begin
        stall_cnt[i] <= '0;
      end else if (bus.req_valid[i] && !grant[i] && (stall_cnt[i] != 32'hFFFF_FFFF)) begin
        stall_cnt[i] <= stall_cnt[i] + 32'd1;
      end
    end
  end

  assign perf_stall_count = {stall_cnt[1], stall_cnt[0]};
`endif

endmodule

// File: tb/tb_cpu_alu_arbiter.sv
// Directed self-checking bench for cpu_alu_arbiter (honours CPU_ALU_ARBITER_PERF_COUNTERS_EN).
module tb_cpu_alu_arbiter;
  import cpu_alu_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  cpu_alu_arbiter_if #(.TAG_WIDTH(4)) bus ();

`ifdef CPU_ALU_ARBITER_PERF_COUNTERS_EN
  logic [63:0] perf_stall_count;
`endif

  cpu_alu_arbiter #(.TAG_WIDTH(4), .INIT_LAST_GRANT(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef CPU_ALU_ARBITER_PERF_COUNTERS_EN
    ,
    .perf_stall_count (perf_stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic [6:0] f7, input logic [2:0] f3,
                          input logic [6:0] opc, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag);
    bus.req_funct7[p*7 +: 7] = f7;
    bus.req_funct3[p*3 +: 3] = f3;
    bus.req_opcode[p*7 +: 7] = opc;
    bus.req_a[p*32 +: 32]    = a;
    bus.req_b[p*32 +: 32]    = b;
    bus.req_tag[p*4 +: 4]    = tag;
  endtask

  // Single-port op with rsp_ready=11: accept, one-cycle result, then drain.
  task automatic run_one(input string name, input int p, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [6:0] opc, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input logic [31:0] exp_res);
    logic [1:0] oh;
    oh = (p == 1) ? 2'b10 : 2'b01;
    set_port(p, f7, f3, opc, a, b, tag);
    bus.req_valid = oh;
    #1;
    chk({name, "_req_ready"}, 64'(bus.req_ready), 64'(oh));
    tick();
    bus.req_valid = 2'b00;
    chk({name, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(oh));
    chk({name, "_result"}, 64'(bus.rsp_result), 64'(exp_res));
    chk({name, "_tag"}, 64'(bus.rsp_tag), 64'(tag));
    tick();
    chk({name, "_drained"}, 64'(bus.rsp_valid), 64'd0);
  endtask

  initial begin
    logic [1:0] exp_g;
    checks   = 0;
    failures = 0;
    reset          = 1'b1;
    bus.req_valid  = '0;
    bus.req_funct7 = '0;
    bus.req_funct3 = '0;
    bus.req_opcode = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_tag    = '0;
    bus.rsp_ready  = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;

    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_result", 64'(bus.rsp_result), 64'd0);
    chk("reset_tag", 64'(bus.rsp_tag), 64'd0);
    chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
`ifdef CPU_ALU_ARBITER_PERF_COUNTERS_EN
    chk("reset_perf", perf_stall_count, 64'd0);
`endif

    // Single-port ALU vectors.
    bus.rsp_ready = 2'b11;
    run_one("p0_add",     0, 7'h00, F3_ADD_SUB, OPCODE_OP,     32'd5, 32'd7, 4'd3, 32'd12);
    run_one("p1_sub",     1, 7'h20, F3_ADD_SUB, OPCODE_OP,     32'd3, 32'd5, 4'd5, 32'hFFFF_FFFE);
    run_one("p1_addi",    1, 7'h20, F3_ADD_SUB, OPCODE_OP_IMM, 32'd3, 32'd5, 4'd6, 32'd8);
    run_one("p1_sra",     1, 7'h20, F3_SRL_SRA, OPCODE_OP,     32'h8000_0000, 32'd4, 4'd7, 32'hF800_0000);
    run_one("p0_srl",     0, 7'h00, F3_SRL_SRA, OPCODE_OP,     32'h8000_0000, 32'd4, 4'd8, 32'h0800_0000);
    run_one("p0_slt",     0, 7'h00, F3_SLT,     OPCODE_OP,     32'hFFFF_FFFF, 32'd1, 4'd1, 32'd1);
    run_one("p0_sltu",    0, 7'h00, F3_SLTU,    OPCODE_OP,     32'hFFFF_FFFF, 32'd1, 4'd2, 32'd0);
    run_one("p1_xor",     1, 7'h00, F3_XOR,     OPCODE_OP,     32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'hA, 32'hFF00_FF00);
    run_one("p0_and",     0, 7'h00, F3_AND,     OPCODE_OP,     32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'hB, 32'h00F0_00F0);
    run_one("p1_or",      1, 7'h00, F3_OR,      OPCODE_OP,     32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'hC, 32'hFFF0_FFF0);
    run_one("p0_sll_wrap",0, 7'h00, F3_SLL,     OPCODE_OP,     32'd1, 32'd33, 4'hD, 32'd2);

    // Round-robin under constant contention; pointer reset so port 0 wins first.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_port(0, 7'h00, F3_ADD_SUB, OPCODE_OP, 32'd1, 32'd1, 4'd1);
    set_port(1, 7'h00, F3_ADD_SUB, OPCODE_OP, 32'd10, 32'd20, 4'd2);
    bus.req_valid = 2'b11;
    #1;
    exp_g = 2'b01;
    for (int k = 0; k < 4; k++) begin
      chk("rr_req_ready", 64'(bus.req_ready), 64'(exp_g));
      tick();
      chk("rr_rsp_valid", 64'(bus.rsp_valid), 64'(exp_g));
      chk("rr_result", 64'(bus.rsp_result), (exp_g == 2'b01) ? 64'd2 : 64'd30);
      chk("rr_tag", 64'(bus.rsp_tag), (exp_g == 2'b01) ? 64'd1 : 64'd2);
      exp_g = {exp_g[0], exp_g[1]};
    end
    bus.req_valid = 2'b00;
    tick();
    chk("rr_drained", 64'(bus.rsp_valid), 64'd0);

    // Backpressure: port 0 holds the slot while port 1 waits.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.rsp_ready = 2'b00;
    set_port(0, 7'h00, F3_ADD_SUB, OPCODE_OP, 32'd5, 32'd7, 4'd3);
    bus.req_valid = 2'b01;
    #1;
    chk("bp_accept0", 64'(bus.req_ready), 64'd1);
    tick();
    set_port(1, 7'h20, F3_ADD_SUB, OPCODE_OP, 32'd3, 32'd5, 4'd9);
    bus.req_valid = 2'b10;
    #1;
    chk("bp_blocked", 64'(bus.req_ready), 64'd0);
    chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    tick();
    chk("bp_blocked1", 64'(bus.req_ready), 64'd0);
    chk("bp_result1", 64'(bus.rsp_result), 64'd12);
    chk("bp_tag1", 64'(bus.rsp_tag), 64'd3);
    tick();
    bus.rsp_ready = 2'b10;
    #1;
    chk("bp_nonowner_ignored", 64'(bus.req_ready), 64'd0);
    tick();
    chk("bp_rsp_valid3", 64'(bus.rsp_valid), 64'd1);
    chk("bp_result3", 64'(bus.rsp_result), 64'd12);
    chk("bp_tag3", 64'(bus.rsp_tag), 64'd3);
`ifdef CPU_ALU_ARBITER_PERF_COUNTERS_EN
    chk("perf_port1_stall3", 64'(perf_stall_count[63:32]), 64'd3);
    chk("perf_port0_none", 64'(perf_stall_count[31:0]), 64'd0);
`endif
    bus.rsp_ready = 2'b01;
    #1;
    chk("bp_passthrough_ready", 64'(bus.req_ready), 64'd2);
    tick();
    bus.req_valid = 2'b00;
    chk("bp_owner_switch", 64'(bus.rsp_valid), 64'd2);
    chk("bp_result_p1", 64'(bus.rsp_result), 64'hFFFF_FFFE);
    chk("bp_tag_p1", 64'(bus.rsp_tag), 64'd9);
    bus.rsp_ready = 2'b11;
    tick();
    chk("bp_drained", 64'(bus.rsp_valid), 64'd0);

    // Reset while the slot is full; pointer must return to its reset value.
    bus.rsp_ready = 2'b00;
    set_port(0, 7'h00, F3_ADD_SUB, OPCODE_OP, 32'd5, 32'd7, 4'd4);
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    chk("rst_mid_full", 64'(bus.rsp_valid), 64'd1);
    reset = 1'b1;
    tick();
    chk("rst_mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
`ifdef CPU_ALU_ARBITER_PERF_COUNTERS_EN
    chk("rst_mid_perf", perf_stall_count, 64'd0);
`endif
    reset = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    chk("rst_mid_last_grant", 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = 2'b00;
    chk("rst_mid_owner", 64'(bus.rsp_valid), 64'd1);
    chk("rst_mid_tag", 64'(bus.rsp_tag), 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
